// File: rtl/fp_mul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// rounding modes, flag positions, operand classes and the canonical NaN.
package fp_mul_pkg;

    localparam logic RND_RNE = 1'b0;
    localparam logic RND_RTZ = 1'b1;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } op_class_e;

    // Quiet NaN: sign 0, exponent all-ones, only the mantissa MSB set.
    function automatic logic [63:0] canonical_nan(input int unsigned exp_w,
                                                  input int unsigned man_w);
        return ((64'd1 << (exp_w + 1)) - 64'd1) << (man_w - 1);
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Combinational round, overflow/underflow resolution and pack for the final
// multiplier stage. Subnormal results flush to signed zero.
module fp_mul_round
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   rnd_mode,
    input  logic                   sign,
    input  logic [EXP_W+1:0]       exp_pre,
    input  logic [MAN_W-1:0]       frac,
    input  logic                   guard,
    input  logic                   sticky,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_OVF = XW'((1 << EXP_W) - 1);

    logic                 inc;
    logic [MAN_W:0]       sum;
    logic signed [XW-1:0] exp_rnd;

    // NOTE: every output of this block is assigned a default first, so no path
    // through the if/else can leave a latch behind.
    always_comb begin
        inc     = (rnd_mode == RND_RNE) && guard && (frac[0] || sticky);
        sum     = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        exp_rnd = $signed(exp_pre) + $signed({{(XW-1){1'b0}}, sum[MAN_W]});
        result  = {sign, exp_rnd[EXP_W-1:0], sum[MAN_W-1:0]};
        flags   = '0;
        flags[FLAG_INEXACT] = guard || sticky;

        if (exp_rnd >= EXP_OVF) begin
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
            if (rnd_mode == RND_RTZ)
                result = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            else
                result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_rnd[XW-1] || exp_rnd == '0) begin
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mul_pipe_param.sv
// Elastic 3-stage floating-point multiplier: unpack/multiply, normalise,
// round/pack, with a valid/ready chain that stalls without inserting bubbles.
module fp_mul_pipe_param
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                  clk_59,
    input  logic                  rst_59,
    input  logic                  in_valid_59,
    output logic                  in_ready_59,
    input  logic [EXP_W+MAN_W:0]  a_59,
    input  logic [EXP_W+MAN_W:0]  b_59,
    input  logic                  rnd_mode_59,
    input  logic [TAG_W-1:0]      in_tag_59,
    output logic                  out_valid_59,
    input  logic                  out_ready_59,
    output logic [EXP_W+MAN_W:0]  result_59,
    output logic [3:0]            flags_59,
    output logic [TAG_W-1:0]      out_tag_59
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int XW   = EXP_W + 2;
    localparam int PW   = 2 * (MAN_W + 1);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [W-1:0] QNAN = W'(canonical_nan(EXP_W, MAN_W));

    typedef struct packed {
        logic             sign;
        logic [XW-1:0]    exp;
        logic [PW-1:0]    prod;
        logic             special;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flags;
        logic             rnd_mode;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [XW-1:0]    exp;
        logic [MAN_W-1:0] frac;
        logic             guard;
        logic             sticky;
        logic             special;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flags;
        logic             rnd_mode;
        logic [TAG_W-1:0] tag;
    } s2_t;

    function automatic op_class_e classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        e = x[W-2:MAN_W];
        if (e == '0)
            return ZERO;
        if (e == '1)
            return (x[MAN_W-1:0] == '0) ? INF : NAN;
        return NORM;
    endfunction

    logic      v1, v2, v3;
    logic      rdy1, rdy2, rdy3;
    op_class_e cls_a, cls_b;
    s1_t       s1_d, s1_q;
    s2_t       s2_d, s2_q;
    logic      msb;
    logic [W-1:0] rnd_result;
    logic [3:0]   rnd_flags;

    assign rdy3         = !v3 || out_ready_59;
    assign rdy2         = !v2 || rdy3;
    assign rdy1         = !v1 || rdy2;
    assign in_ready_59  = rdy1;
    assign out_valid_59 = v3;

    // Stage 1: classify, sign, exponent sum and full mantissa product.
    always_comb begin
        cls_a = classify(a_59);
        cls_b = classify(b_59);
        s1_d  = '0;
        s1_d.sign = a_59[W-1] ^ b_59[W-1];
        s1_d.exp  = {2'b00, a_59[W-2:MAN_W]} + {2'b00, b_59[W-2:MAN_W]} - XW'(BIAS);
        s1_d.prod = PW'({1'b1, a_59[MAN_W-1:0]}) * PW'({1'b1, b_59[MAN_W-1:0]});
        s1_d.rnd_mode = rnd_mode_59;
        s1_d.tag      = in_tag_59;

        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = QNAN;
            s1_d.spec_flags[FLAG_INVALID] = 1'b1;
        end else if (cls_a == INF || cls_b == INF) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {s1_d.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            s1_d.special  = 1'b1;
            s1_d.spec_res = {s1_d.sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    // Stage 2: a product in [2,4) shifts right once; the hidden bit is dropped.
    always_comb begin
        s2_d = '0;
        msb  = s1_q.prod[PW-1];
        s2_d.sign       = s1_q.sign;
        s2_d.exp        = s1_q.exp + XW'(msb);
        s2_d.special    = s1_q.special;
        s2_d.spec_res   = s1_q.spec_res;
        s2_d.spec_flags = s1_q.spec_flags;
        s2_d.rnd_mode   = s1_q.rnd_mode;
        s2_d.tag        = s1_q.tag;
        if (msb) begin
            s2_d.frac   = s1_q.prod[PW-2 -: MAN_W];
            s2_d.guard  = s1_q.prod[MAN_W];
            s2_d.sticky = |s1_q.prod[MAN_W-1:0];
        end else begin
            s2_d.frac   = s1_q.prod[PW-3 -: MAN_W];
            s2_d.guard  = s1_q.prod[MAN_W-1];
            s2_d.sticky = |s1_q.prod[MAN_W-2:0];
        end
    end

    fp_mul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .rnd_mode (s2_q.rnd_mode),
        .sign     (s2_q.sign),
        .exp_pre  (s2_q.exp),
        .frac     (s2_q.frac),
        .guard    (s2_q.guard),
        .sticky   (s2_q.sticky),
        .result   (rnd_result),
        .flags    (rnd_flags)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    always_ff @(posedge clk_59 or negedge rst_59) begin
        if (!rst_59) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (rdy1) v1 <= in_valid_59;
            if (rdy2) v2 <= v1;
            if (rdy3) v3 <= v2;
        end
    end

    // NOTE: intermediate stage data carries no reset; it is only ever observed
    // behind its valid bit, which the reset does clear.
    always_ff @(posedge clk_59) begin
        if (in_valid_59 && rdy1) s1_q <= s1_d;
        if (v1 && rdy2)          s2_q <= s2_d;
    end

    always_ff @(posedge clk_59 or negedge rst_59) begin
        if (!rst_59) begin
            result_59  <= '0;
            flags_59   <= '0;
            out_tag_59 <= '0;
        end else if (v2 && rdy3) begin
            result_59  <= s2_q.special ? s2_q.spec_res   : rnd_result;
            flags_59   <= s2_q.special ? s2_q.spec_flags : rnd_flags;
            out_tag_59 <= s2_q.tag;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe_param.sv
// Self-checking bench for fp_mul_pipe_param (binary16 defaults): directed
// cases, backpressure, mid-stream reset and a randomized elastic phase.
module tb_fp_mul_pipe_param;

    localparam int TAG_W = 4;
    localparam int W     = 16;

    logic             clk_59 = 1'b0;
    logic             rst_59;
    logic             in_valid_59;
    logic             in_ready_59;
    logic [W-1:0]     a_59;
    logic [W-1:0]     b_59;
    logic             rnd_mode_59;
    logic [TAG_W-1:0] in_tag_59;
    logic             out_valid_59;
    logic             out_ready_59;
    logic [W-1:0]     result_59;
    logic [3:0]       flags_59;
    logic [TAG_W-1:0] out_tag_59;

    fp_mul_pipe_param dut (
        .clk_59       (clk_59),
        .rst_59       (rst_59),
        .in_valid_59  (in_valid_59),
        .in_ready_59  (in_ready_59),
        .a_59         (a_59),
        .b_59         (b_59),
        .rnd_mode_59  (rnd_mode_59),
        .in_tag_59    (in_tag_59),
        .out_valid_59 (out_valid_59),
        .out_ready_59 (out_ready_59),
        .result_59    (result_59),
        .flags_59     (flags_59),
        .out_tag_59   (out_tag_59)
    );

    always #5 clk_59 = ~clk_59;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
        int          t;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    bit          use_dir = 1'b0;
    logic [15:0] dir_res;
    logic [3:0]  dir_flg;
    bit          lat_chk = 1'b0;
    bit          hold_pend = 1'b0;
    logic [15:0] held_res;
    logic [3:0]  held_flg;
    logic [3:0]  held_tag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded
    // remainder against half an ulp. Returns {flags, result}.
    function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic mode);
        int     ea, eb, e, sh;
        longint ma, mb, p, q, rem, half;
        logic   s, inx, za, zb, ia, ib, na, nb;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = longint'(a[9:0]);
        mb = longint'(b[9:0]);
        s  = a[15] ^ b[15];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 31) && (ma == 0);
        ib = (eb == 31) && (mb == 0);
        na = (ea == 31) && (ma != 0);
        nb = (eb == 31) && (mb != 0);
        if (na || nb || (ia && zb) || (za && ib)) return {4'b1000, 16'h7E00};
        if (ia || ib) return {4'b0000, s, 5'h1F, 10'h000};
        if (za || zb) return {4'b0000, s, 15'h0000};
        p  = (1024 + ma) * (1024 + mb);
        e  = ea + eb - 15;
        sh = 10;
        if (p >= 64'd2097152) begin
            sh = 11;
            e++;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (mode == 1'b0 && (rem > half || (rem == half && q[0]))) q++;
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e >= 31) return mode ? {4'b0101, s, 5'h1E, 10'h3FF} : {4'b0101, s, 5'h1F, 10'h000};
        if (e <= 0)  return {4'b0011, s, 15'h0000};
        return {3'b000, inx, s, e[4:0], q[9:0]};
    endfunction

    function automatic logic [15:0] rnd_operand();
        logic [15:0] x;
        x = 16'($urandom);
        case ($urandom_range(0, 7))
            0: x[14:10] = 5'd0;
            1: x[14:10] = 5'h1F;
            2: x[14:10] = 5'(16 + $urandom_range(0, 14));
            3: x[14:10] = 5'($urandom_range(1, 7));
            default: ;
        endcase
        return x;
    endfunction

    // One cycle: inputs were set at the falling edge; evaluate, then cross the rising edge.
    task automatic tick(output bit acc, output bit emit);
        exp_t        e;
        logic [19:0] m;
        #1;
        acc  = in_valid_59 && in_ready_59;
        emit = out_valid_59 && out_ready_59;
        check("in_ready", in_ready_59, !(sb.size() == 3 && !out_ready_59));
        if (sb.size() == 0) check("idle_valid", out_valid_59, 0);
        if (hold_pend) begin
            check("hold_valid",  out_valid_59, 1);
            check("hold_result", result_59, held_res);
            check("hold_flags",  flags_59, held_flg);
            check("hold_tag",    out_tag_59, held_tag);
        end
        if (emit && sb.size() != 0) begin
            e = sb.pop_front();
            check("result", result_59, e.res);
            check("flags",  flags_59, e.flg);
            check("tag",    out_tag_59, e.tag);
            if (lat_chk) check("latency", cyc - e.t, 3);
        end
        hold_pend = out_valid_59 && !out_ready_59;
        held_res  = result_59;
        held_flg  = flags_59;
        held_tag  = out_tag_59;
        if (acc) begin
            m     = ref_mul(a_59, b_59, rnd_mode_59);
            e.res = use_dir ? dir_res : m[15:0];
            e.flg = use_dir ? dir_flg : m[19:16];
            e.tag = in_tag_59;
            e.t   = cyc;
            sb.push_back(e);
        end
        @(posedge clk_59);
        @(negedge clk_59);
        cyc++;
    endtask

    task automatic offer(input logic [15:0] a, input logic [15:0] b, input logic mode,
                         input logic [3:0] tag);
        bit acc, em;
        int n;
        n = 0;
        a_59 = a;
        b_59 = b;
        rnd_mode_59 = mode;
        in_tag_59 = tag;
        in_valid_59 = 1'b1;
        do begin
            tick(acc, em);
            n++;
        end while (!acc && n < 20);
        check("offer_accepted", acc, 1);
        in_valid_59 = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic mode,
                        input logic [3:0] tag, input logic [15:0] res, input logic [3:0] flg);
        use_dir = 1'b1;
        dir_res = res;
        dir_flg = flg;
        offer(a, b, mode, tag);
        use_dir = 1'b0;
    endtask

    task automatic drain();
        bit acc, em;
        int n;
        n = 0;
        in_valid_59  = 1'b0;
        out_ready_59 = 1'b1;
        while (sb.size() != 0 && n < 20) begin
            tick(acc, em);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          acc, em;
        int          k, nem;
        logic [15:0] bp_a[5];
        logic [15:0] bp_b[5];

        rst_59 = 1'b0;
        in_valid_59 = 1'b0;
        out_ready_59 = 1'b0;
        a_59 = '0;
        b_59 = '0;
        rnd_mode_59 = 1'b0;
        in_tag_59 = '0;
        #3;
        check("rst_out_valid", out_valid_59, 0);
        check("rst_result", result_59, 0);
        check("rst_flags", flags_59, 0);
        check("rst_tag", out_tag_59, 0);
        check("rst_in_ready", in_ready_59, 1);
        @(negedge clk_59);
        rst_59 = 1'b1;

        // Back-to-back directed beats with latency check.
        out_ready_59 = 1'b1;
        lat_chk = 1'b1;
        send(16'h5620, 16'h5948, 1'b0, 4'd1, 16'h740B, 4'b0001);
        send(16'h5630, 16'hD590, 1'b0, 4'd2, 16'hF04D, 4'b0001);
        send(16'h3C00, 16'h3C00, 1'b0, 4'd3, 16'h3C00, 4'b0000);
        drain();
        lat_chk = 1'b0;

        // Overflow in both modes, specials, underflow.
        send(16'h7BFF, 16'h7BFF, 1'b0, 4'd4, 16'h7C00, 4'b0101);
        send(16'h7BFF, 16'h7BFF, 1'b1, 4'd5, 16'h7BFF, 4'b0101);
        send(16'h7C00, 16'h0000, 1'b0, 4'd6, 16'h7E00, 4'b1000);
        send(16'h0000, 16'hD750, 1'b0, 4'd7, 16'h8000, 4'b0000);
        send(16'h0400, 16'h0400, 1'b0, 4'd8, 16'h0000, 4'b0011);
        send(16'hFC00, 16'h4000, 1'b1, 4'd9, 16'hFC00, 4'b0000);
        drain();

        // Backpressure: 5 beats offered against a stalled consumer.
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = rnd_operand();
            bp_b[i] = rnd_operand();
        end
        out_ready_59 = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            a_59 = bp_a[k];
            b_59 = bp_b[k];
            rnd_mode_59 = k[0];
            in_tag_59 = 4'(k + 10);
            in_valid_59 = 1'b1;
            tick(acc, em);
            if (acc) k++;
        end
        check("bp_accepted", k, 3);
        check("bp_in_ready_low", in_ready_59, 0);
        out_ready_59 = 1'b1;
        nem = 0;
        for (int i = 0; i < 5; i++) begin
            if (k < 5) begin
                a_59 = bp_a[k];
                b_59 = bp_b[k];
                rnd_mode_59 = k[0];
                in_tag_59 = 4'(k + 10);
                in_valid_59 = 1'b1;
            end else begin
                in_valid_59 = 1'b0;
            end
            tick(acc, em);
            if (acc) k++;
            if (em) nem++;
        end
        check("bp_no_gaps", nem, 5);
        drain();

        // Mid-stream reset with two operations in flight.
        offer(rnd_operand(), rnd_operand(), 1'b0, 4'd1);
        offer(rnd_operand(), rnd_operand(), 1'b1, 4'd2);
        out_ready_59 = 1'b0;
        tick(acc, em);
        check("pre_rst_valid", out_valid_59, 1);
        #2;
        rst_59 = 1'b0;
        #1;
        check("async_rst_valid", out_valid_59, 0);
        check("async_rst_result", result_59, 0);
        check("async_rst_flags", flags_59, 0);
        check("async_rst_tag", out_tag_59, 0);
        check("async_rst_in_ready", in_ready_59, 1);
        sb.delete();
        hold_pend = 1'b0;
        @(posedge clk_59);
        @(negedge clk_59);
        rst_59 = 1'b1;
        out_ready_59 = 1'b1;
        repeat (8) tick(acc, em);
        offer(16'h4200, 16'hC500, 1'b0, 4'd15);
        drain();

        // Randomized elastic traffic; a beat is held until accepted.
        acc = 1'b0;
        in_valid_59 = 1'b0;
        repeat (400) begin
            if (!in_valid_59 || acc) begin
                in_valid_59 = ($urandom_range(0, 9) < 7);
                a_59 = rnd_operand();
                b_59 = rnd_operand();
                rnd_mode_59 = 1'($urandom_range(0, 1));
                in_tag_59 = TAG_W'($urandom);
            end
            out_ready_59 = ($urandom_range(0, 9) < 7);
            tick(acc, em);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
